sdram_arbiter: RTL

Slot-based scheduler that shares the single read/write channel of the `sdram` controller between three requesters: CPU/cart bus, DMA/HDMA engine, and the save-state engine. It generates the controller's `sync` slot strobe, picks one requester per 8-clock slot, drives the controller's request port, and returns read data plus a one-cycle acknowledge to the winner. It also forces idle slots so the controller can issue its auto-refresh.

---
 rtl/sdram_arb_pkg.sv | 43 ++++
 rtl/sdram_arb_pick.sv | 62 ++++++
 rtl/sdram_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  sdram_arb_pkg
//  Shared constants and types for the three-port SDRAM slot arbiter.
//  Revision: 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    localparam int NPORTS    = 3;
    localparam int PORT_CPU  = 0;
    localparam int PORT_DMA  = 1;
    localparam int PORT_SAVE = 2;

    // mem_sync is high for slot cycles 0..SYNC_HI_LAST
    localparam int SYNC_HI_LAST = 3;

    // The grant decision happens on the last cycle of a slot
    function automatic int decide_at(input int slot_len);
        return slot_len - 1;
    endfunction

    localparam int DECIDE_AT = decide_at(8);

    // Winner code; 3 means the slot is idle
    typedef enum logic [1:0] {
        GRANT_CPU  = 2'd0,
        GRANT_DMA  = 2'd1,
        GRANT_SAVE = 2'd2,
        GRANT_NONE = 2'd3
    } grant_t;

    // Lowest set bit of a port vector as a grant code, or GRANT_NONE
    function automatic grant_t lowest_set(input logic [NPORTS-1:0] v);
        grant_t r;
        r = GRANT_NONE;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (v[i]) r = grant_t'(i[1:0]);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_arb_pick.sv
`default_nettype none
// ============================================================================
//  sdram_arb_pick
//  Per-slot winner selection: fixed priority with starvation promotion and a
//  forced idle slot after a run of granted slots so refresh can happen.
//  Revision: 1.0 - initial release
// ============================================================================
module sdram_arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int STARVE_MAX    = 4,
    parameter int REFRESH_SLOTS = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              decide,
    input  logic [NPORTS-1:0] req,
    output grant_t            grant_next,
    output grant_t            grant
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    localparam logic [6:0] BUSY_LIM   = 7'(REFRESH_SLOTS);

    logic [NPORTS-1:0][2:0] wait_cnt;
    logic [6:0]             busy_cnt;
    logic [NPORTS-1:0]      starving;

    // A pending port that has lost too many slots in a row
    for (genvar i = 0; i < NPORTS; i++) begin : g_starve
        assign starving[i] = req[i] && (wait_cnt[i] >= STARVE_LIM);
    end

    // Refresh beats everything, then starving ports, then plain priority
    always_comb begin
        grant_next = GRANT_NONE;
        if (busy_cnt != BUSY_LIM) begin
            if (|starving) grant_next = lowest_set(starving);
            else           grant_next = lowest_set(req);
        end
    end

    // Register the decision and age the counters once per slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant    <= GRANT_NONE;
            busy_cnt <= 7'd0;
            wait_cnt <= '0;
        end else if (decide) begin
            grant    <= grant_next;
            busy_cnt <= (grant_next == GRANT_NONE) ? 7'd0 : busy_cnt + 7'd1;
            for (int i = 0; i < NPORTS; i++) begin
                if (req[i] && (grant_next != grant_t'(i[1:0])))
                    wait_cnt[i] <= (wait_cnt[i] == 3'd7) ? 3'd7 : wait_cnt[i] + 3'd1;
                else
                    wait_cnt[i] <= 3'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  sdram_arbiter
//  Slot scheduler sharing one SDRAM controller channel between the CPU, DMA
//  and save-state ports. Generates the slot strobe, muxes the winner onto the
//  controller and returns read data with a one-cycle acknowledge.
//  Revision: 1.0 - initial release
// ============================================================================
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int SLOT_LEN      = 8,
    parameter int READ_AT       = 7,
    parameter int STARVE_MAX    = 4,
    parameter int REFRESH_SLOTS = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NPORTS-1:0]       req,
    input  logic [NPORTS-1:0]       we,
    input  logic [NPORTS-1:0][23:0] addr,
    input  logic [NPORTS-1:0][1:0]  ds,
    input  logic [NPORTS-1:0][15:0] din,
    output logic [15:0]             dout,
    output logic [NPORTS-1:0]       ack,
    output logic                    mem_sync,
    output logic                    mem_oe,
    output logic                    mem_we,
    output logic [23:0]             mem_addr,
    output logic [1:0]              mem_ds,
    output logic [15:0]             mem_din,
    input  logic [15:0]             mem_dout
);

    localparam int             SW        = $clog2(SLOT_LEN);
    localparam logic [SW-1:0]  LAST      = SW'(decide_at(SLOT_LEN));
    localparam logic [SW-1:0]  SYNC_OFF  = SW'(SYNC_HI_LAST);
    // ack is registered one cycle early so it is visible during READ_AT
    localparam logic [SW-1:0]  ACK_EDGE  = SW'(READ_AT - 1);

    logic [SW-1:0] slot;
    logic          decide;
    grant_t        grant_next;
    grant_t        grant;

    assign decide = (slot == LAST);

    sdram_arb_pick #(
        .STARVE_MAX    (STARVE_MAX),
        .REFRESH_SLOTS (REFRESH_SLOTS)
    ) u_pick (
        .clk        (clk),
        .reset_n    (reset_n),
        .decide     (decide),
        .req        (req),
        .grant_next (grant_next),
        .grant      (grant)
    );

    // Free-running slot cycle counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) slot <= '0;
        else          slot <= decide ? '0 : slot + 1'b1;
    end

    // Slot strobe: rises entering cycle 0, falls entering cycle SYNC_HI_LAST+1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              mem_sync <= 1'b0;
        else if (decide)           mem_sync <= 1'b1;
        else if (slot == SYNC_OFF) mem_sync <= 1'b0;
    end

    // Latch the winner's request for the whole next slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_oe   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= 24'd0;
            mem_ds   <= 2'd0;
            mem_din  <= 16'd0;
        end else if (decide) begin
            if (grant_next != GRANT_NONE) begin
                mem_oe   <= ~we[grant_next];
                mem_we   <= we[grant_next];
                mem_addr <= addr[grant_next];
                mem_ds   <= ds[grant_next];
                mem_din  <= din[grant_next];
            end else begin
                mem_oe   <= 1'b0;
                mem_we   <= 1'b0;
            end
        end
    end

    // One-cycle ack to the slot owner and read-data capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack  <= '0;
            dout <= 16'd0;
        end else begin
            ack <= '0;
            if ((slot == ACK_EDGE) && (grant != GRANT_NONE)) begin
                ack[grant] <= 1'b1;
                if (mem_oe) dout <= mem_dout;
            end
        end
    end

endmodule
`default_nettype wire
